// File: rtl/jk_ms_pkg.sv
// ============================================================================
//  Module      : jk_ms_pkg
//  Description : Shared types and the JK next-state function for the
//                master-slave JK flip-flop bank.
//  Contents    : jk_cmd_t - per-bit JK command encoding {J,K}
//                jk_next  - next-state value for one bit given cmd and Q
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_ms_pkg;

  // Encoding is simply {J,K}, so a bit pair can be cast straight to it.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  function automatic logic jk_next(input jk_cmd_t cmd, input logic q);
    logic r;
    case (cmd)
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_ms_latch.sv
// ============================================================================
//  Module      : jk_ms_latch
//  Description : WIDTH-bit gated D latch with asynchronous clear and preset.
//                Transparent while i_en=1, holds while i_en=0.
//                Clear (i_rst_n=0) has priority over preset (i_set_n=0).
//  Ports       : i_en    - latch enable (transparent when high)
//                i_rst_n - async active-low clear to RESET_VAL
//                i_set_n - async active-low preset to all-ones
//                i_d     - data in   [WIDTH]
//                o_q     - data out  [WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ms_latch #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_en,
  input  logic             i_rst_n,
  input  logic             i_set_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_latch begin
    if (!i_rst_n) begin
      r_q = RESET_VAL;
    end else if (!i_set_n) begin
      r_q = '1;
    end else if (i_en) begin
      r_q = i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/jk_flip_flop_master_slave.sv
// ============================================================================
//  Module      : jk_flip_flop_master_slave
//  Description : Bank of WIDTH independent master-slave JK flip-flops.
//                Master latch is open while C=1 and computes the JK next
//                state from the (stable) slave output; slave latch is open
//                while C=0, so Q only changes at the falling edge of C.
//  Ports       : C      - clock, falling edge is the effective edge
//                RESETn - async active-low reset, loads RESET_VAL
//                SETn   - async active-low preset to all-ones
//                         (only present when JKMS_PRESET_EN is defined;
//                          RESETn wins over SETn)
//                J, K   - per-bit set / reset requests   [WIDTH]
//                Q, Qn  - slave output and its complement [WIDTH]
//  Config      : JKMS_PRESET_EN - adds SETn and the preset path
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_flip_flop_master_slave
  import jk_ms_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             C,
  input  logic             RESETn,
`ifdef JKMS_PRESET_EN
  input  logic             SETn,
`endif
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] w_master_d;
  logic [WIDTH-1:0] w_master_q;
  logic [WIDTH-1:0] w_slave_q;
  logic             w_set_n;
  logic             w_c_n;

`ifdef JKMS_PRESET_EN
  assign w_set_n = SETn;
`else
  assign w_set_n = 1'b1;
`endif

  assign w_c_n = ~C;

  // Next state uses the slave output, which is frozen while the master is
  // open, so a held JK=11 toggles exactly once per C period.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_master_d[i] = jk_next(jk_cmd_t'({J[i], K[i]}), w_slave_q[i]);
  end

  jk_ms_latch #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_master (
    .i_en    (C),
    .i_rst_n (RESETn),
    .i_set_n (w_set_n),
    .i_d     (w_master_d),
    .o_q     (w_master_q)
  );

  jk_ms_latch #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_slave (
    .i_en    (w_c_n),
    .i_rst_n (RESETn),
    .i_set_n (w_set_n),
    .i_d     (w_master_q),
    .o_q     (w_slave_q)
  );

  assign Q  = w_slave_q;
  assign Qn = ~w_slave_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_flip_flop_master_slave.sv
// ============================================================================
//  Module      : tb_jk_flip_flop_master_slave
//  Description : Self-checking bench for a 4-bit master-slave JK bank.
//                Directed reset / JK sequences, then randomized J/K with
//                high-phase glitches, compared against a behavioural model.
//  Config      : JKMS_PRESET_EN - also exercises SETn
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_flip_flop_master_slave;

  localparam int         W      = 4;
  localparam logic [3:0] C_RVAL = 4'b0011;

  logic         C;
  logic         RESETn;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] Q;
  logic [W-1:0] Qn;
`ifdef JKMS_PRESET_EN
  logic         SETn;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  jk_flip_flop_master_slave #(
    .WIDTH     (W),
    .RESET_VAL (C_RVAL)
  ) dut (
    .C      (C),
    .RESETn (RESETn),
`ifdef JKMS_PRESET_EN
    .SETn   (SETn),
`endif
    .J      (J),
    .K      (K),
    .Q      (Q),
    .Qn     (Qn)
  );

  // C starts high, falling edges at 25, 75, 125, ...
  initial begin
    C = 1'b1;
    forever #25 C = ~C;
  end

  // Behavioural reference: value of Q as seen from outside.
  logic [W-1:0] mdl_q;
  bit           armed;   // a high phase out of reset/preset has been seen
  logic         c_prev;

  always @(C or RESETn
`ifdef JKMS_PRESET_EN
           or SETn
`endif
          ) begin
    if (RESETn !== 1'b1) begin
      mdl_q = C_RVAL;
      armed = 1'b0;
    end
`ifdef JKMS_PRESET_EN
    else if (SETn !== 1'b1) begin
      mdl_q = '1;
      armed = 1'b0;
    end
`endif
    else if (C) begin
      armed = 1'b1;
    end else if (c_prev === 1'b1 && armed) begin
      for (int b = 0; b < W; b++) begin
        if (J[b] && K[b])      mdl_q[b] = !mdl_q[b];
        else if (J[b])         mdl_q[b] = 1'b1;
        else if (K[b])         mdl_q[b] = 1'b0;
      end
    end
    c_prev = C;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sample(input string tag);
    check_eq({tag, "_q"}, Q, mdl_q);
    check_eq({tag, "_qn"}, Qn, ~mdl_q);
  endtask

  // Called in the low phase: present J/K, sample in the high phase (Q must
  // hold), optionally glitch J/K there, then sample after the falling edge.
  task automatic step(input logic [W-1:0] j, input logic [W-1:0] k,
                      input bit glitch, input string tag);
    J = j;
    K = k;
    @(posedge C);
    #5;
    sample({tag, "_hi"});
    if (glitch) begin
      J = W'($urandom);
      K = W'($urandom);
      #5;
      J = W'($urandom);
      K = W'($urandom);
      #5;
      J = j;
      K = k;
    end
    @(negedge C);
    #5;
    sample({tag, "_lo"});
  endtask

  initial begin
    logic [W-1:0] rj;
    logic [W-1:0] rk;
    RESETn = 1'b0;
`ifdef JKMS_PRESET_EN
    SETn   = 1'b1;
`endif
    J = '1;
    K = '0;

    // Reset state, independent of C.
    #5;
    check_eq("reset_q", Q, C_RVAL);
    check_eq("reset_qn", Qn, ~C_RVAL);
    sample("reset_mdl");

    // Release in the high phase: first falling edge already loads J=1.
    #5;
    RESETn = 1'b1;
    @(negedge C);
    #5;
    check_eq("first_set", Q, 4'b1111);
    sample("first_set_mdl");
    @(posedge C);
    #5;
    check_eq("rise_no_change", Q, 4'b1111);

    @(negedge C);
    #5;
    step(4'b0000, 4'b1111, 1'b0, "clear");
    check_eq("clear_const", Q, 4'b0000);
    step(4'b1111, 4'b1111, 1'b0, "tgl1");
    check_eq("tgl1_const", Q, 4'b1111);
    step(4'b1111, 4'b1111, 1'b0, "tgl2");
    check_eq("tgl2_const", Q, 4'b0000);
    step(4'b1111, 4'b1111, 1'b1, "tgl3");
    check_eq("tgl3_const", Q, 4'b1111);
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 1'b1, "hold");
    check_eq("hold_const", Q, 4'b1111);

    // Async reset mid-high-phase, held across edges with J=1.
    @(posedge C);
    #10;
    RESETn = 1'b0;
    #1;
    check_eq("async_rst", Q, C_RVAL);
    @(negedge C);
    #5;
    step(4'b1111, 4'b0000, 1'b0, "in_rst");
    step(4'b1111, 4'b0000, 1'b0, "in_rst");
    check_eq("in_rst_const", Q, C_RVAL);
    RESETn = 1'b1;   // released in the low phase

    // Mixed per-bit commands from Q=0011.
    step(4'b1010, 4'b0110, 1'b1, "mixed");
    check_eq("mixed_const", Q, 4'b1001);

    for (int i = 0; i < 40; i++) begin
      rj = W'($urandom);
      rk = W'($urandom);
      step(rj, rk, 1'b1, "rand");
      if ($urandom_range(0, 9) == 0) begin
        @(posedge C);
        #7;
        RESETn = 1'b0;
        #1;
        sample("rand_rst");
        #3;
        RESETn = 1'b1;   // still high phase: next fall captures
        @(negedge C);
        #5;
        sample("rand_rst_rel");
      end
    end

`ifdef JKMS_PRESET_EN
    @(posedge C);
    #5;
    SETn = 1'b0;
    #1;
    check_eq("preset", Q, 4'b1111);
    check_eq("preset_qn", Qn, 4'b0000);
    RESETn = 1'b0;
    #1;
    check_eq("rst_over_set", Q, C_RVAL);
    check_eq("rst_over_set_qn", Qn, ~C_RVAL);
    RESETn = 1'b1;
    #1;
    check_eq("preset_again", Q, 4'b1111);
    @(negedge C);
    #5;
    sample("preset_hold");
    SETn = 1'b1;
    step(4'b0000, 4'b1111, 1'b0, "after_preset");
    step(4'b0101, 4'b0000, 1'b0, "after_preset");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
